// File: rtl/cdb_broadcaster_pkg.sv
// Shared sizes, packet types and branch-mask helpers for the CDB broadcaster.
package cdb_broadcaster_pkg;

  localparam int CDB_NUM_FU    = 4;
  localparam int CDB_BUF_DEPTH = 2;
  localparam int CDB_ROB_IDX_W = 5;
  localparam int CDB_PREG_W    = 6;
  localparam int CDB_BMASK_W   = 4;
  localparam int CDB_XLEN      = 32;

  typedef struct packed {
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_PREG_W-1:0]    tag;
    logic [CDB_XLEN-1:0]      result;
    logic [CDB_BMASK_W-1:0]   branch_mask;
    logic                     is_branch;
    logic                     mispredict;
    logic [CDB_BMASK_W-1:0]   branch_tag;
  } fu_complete_packet_t;

  typedef struct packed {
    logic                     valid;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_PREG_W-1:0]    tag;
    logic [CDB_XLEN-1:0]      result;
    logic                     squash_enable;
    logic [CDB_BMASK_W-1:0]   branch_mask;
  } cdb_packet_t;

  function automatic logic depends_on(input logic [CDB_BMASK_W-1:0] mask,
                                      input logic [CDB_BMASK_W-1:0] b);
    return |(mask & b);
  endfunction

  function automatic logic [CDB_BMASK_W-1:0] clear_resolved(input logic [CDB_BMASK_W-1:0] mask,
                                                            input logic [CDB_BMASK_W-1:0] b);
    return mask & ~b;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_fu_buffer.sv
// Per-FU completion FIFO with per-slot valid bits; applies branch squash and
// mask clearing to both buffered entries and the entry accepted this cycle.
module cdb_broadcaster_fu_buffer
  import cdb_broadcaster_pkg::*;
#(
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid_i,
  input  fu_complete_packet_t    in_pkt_i,
  input  logic                   grant_i,
  input  logic                   res_valid_i,
  input  logic                   res_mispredict_i,
  input  logic [CDB_BMASK_W-1:0] res_tag_i,
  output fu_complete_packet_t    head_pkt_o,
  output logic                   head_valid_o,
  output logic                   ready_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fu_complete_packet_t slot_q [BUF_DEPTH];
  fu_complete_packet_t slot_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] slot_valid_q, slot_valid_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  fu_complete_packet_t  in_entry_s;
  logic                 in_kill_s;
  logic                 push_s, pop_s, nonempty_s;

  assign nonempty_s   = (count_q != {CNT_W{1'b0}});
  assign ready_o      = (count_q < CNT_W'(BUF_DEPTH));
  assign head_pkt_o   = slot_q[head_q];
  assign head_valid_o = nonempty_s & slot_valid_q[head_q];
  assign push_s       = in_valid_i & ready_o;
  // A squashed head drains on its own; a live head leaves only when granted.
  assign pop_s        = nonempty_s & (~slot_valid_q[head_q] | grant_i);

  // Next-state: resolution on stored slots, then pop and push bookkeeping.
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    in_entry_s   = in_pkt_i;
    in_kill_s    = 1'b0;

    for (int s = 0; s < BUF_DEPTH; s++) begin
      if (res_valid_i && res_mispredict_i) begin
        if (depends_on(slot_q[s].branch_mask, res_tag_i)) begin
          slot_valid_d[s] = 1'b0;
        end else begin
          slot_valid_d[s] = slot_valid_q[s];
        end
      end else if (res_valid_i) begin
        slot_d[s].branch_mask = clear_resolved(slot_q[s].branch_mask, res_tag_i);
      end else begin
        slot_d[s] = slot_q[s];
      end
    end

    if (res_valid_i && res_mispredict_i) begin
      in_kill_s = depends_on(in_pkt_i.branch_mask, res_tag_i);
    end else if (res_valid_i) begin
      in_entry_s.branch_mask = clear_resolved(in_pkt_i.branch_mask, res_tag_i);
    end else begin
      in_kill_s = 1'b0;
    end

    if (pop_s) begin
      slot_valid_d[head_q] = 1'b0;
      head_d               = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end

    if (push_s) begin
      slot_d[tail_q]       = in_entry_s;
      slot_valid_d[tail_q] = ~in_kill_s;
      tail_d               = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // FIFO state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q       <= {PTR_W{1'b0}};
      tail_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      slot_valid_q <= {BUF_DEPTH{1'b0}};
      for (int s = 0; s < BUF_DEPTH; s++) begin
        slot_q[s] <= {$bits(fu_complete_packet_t){1'b0}};
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      slot_valid_q <= slot_valid_d;
      for (int s = 0; s < BUF_DEPTH; s++) begin
        slot_q[s] <= slot_d[s];
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-FU completion buffers, round-robin arbitration and the
// registered broadcast packet, with branch resolution fed back into the buffers.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU    = CDB_NUM_FU,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int PREG_W    = CDB_PREG_W,
  parameter int BMASK_W   = CDB_BMASK_W,
  parameter int XLEN      = CDB_XLEN
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_valid,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*PREG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_result,
  input  logic [NUM_FU*BMASK_W-1:0] fu_branch_mask,
  input  logic [NUM_FU-1:0]         fu_is_branch,
  input  logic [NUM_FU-1:0]         fu_mispredict,
  input  logic [NUM_FU*BMASK_W-1:0] fu_branch_tag,
  output logic                      cdb_valid,
  output logic [ROB_IDX_W-1:0]      cdb_rob_idx,
  output logic [PREG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]           cdb_result,
  output logic                      cdb_squash_enable,
  output logic [BMASK_W-1:0]        cdb_branch_mask
);

  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  fu_complete_packet_t in_pkt_s   [NUM_FU];
  fu_complete_packet_t head_pkt_s [NUM_FU];
  fu_complete_packet_t win_pkt_s;
  logic [NUM_FU-1:0]   head_valid_s, grant_s;
  logic                found_s, res_valid_s, res_mispredict_s;
  logic [BMASK_W-1:0]  res_tag_s;
  logic [FU_W-1:0]     winner_s, cand_s, rr_ptr_q, rr_ptr_d;
  cdb_packet_t         cdb_q, cdb_d;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign in_pkt_s[g] = '{
      rob_idx:     fu_rob_idx[g*ROB_IDX_W +: ROB_IDX_W],
      tag:         fu_tag[g*PREG_W +: PREG_W],
      result:      fu_result[g*XLEN +: XLEN],
      branch_mask: fu_branch_mask[g*BMASK_W +: BMASK_W],
      is_branch:   fu_is_branch[g],
      mispredict:  fu_mispredict[g],
      branch_tag:  fu_branch_tag[g*BMASK_W +: BMASK_W]
    };

    cdb_broadcaster_fu_buffer #(
      .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
      .clock            (clock),
      .reset            (reset),
      .in_valid_i       (fu_valid[g]),
      .in_pkt_i         (in_pkt_s[g]),
      .grant_i          (grant_s[g]),
      .res_valid_i      (res_valid_s),
      .res_mispredict_i (res_mispredict_s),
      .res_tag_i        (res_tag_s),
      .head_pkt_o       (head_pkt_s[g]),
      .head_valid_o     (head_valid_s[g]),
      .ready_o          (fu_ready[g])
    );
  end

  // Round-robin search: first valid head at or after rr_ptr_q.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_ptr_q;
    cand_s   = rr_ptr_q;
    for (int off = 0; off < NUM_FU; off++) begin
      cand_s = FU_W'((int'(rr_ptr_q) + off) % NUM_FU);
      if (!found_s && head_valid_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant, pointer advance, resolve feedback and next broadcast packet.
  always_comb begin
    grant_s          = {NUM_FU{1'b0}};
    rr_ptr_d         = rr_ptr_q;
    win_pkt_s        = head_pkt_s[winner_s];
    cdb_d            = {$bits(cdb_packet_t){1'b0}};
    res_valid_s      = 1'b0;
    res_mispredict_s = 1'b0;
    res_tag_s        = {BMASK_W{1'b0}};
    if (found_s) begin
      grant_s[winner_s]   = 1'b1;
      rr_ptr_d            = (winner_s == FU_W'(NUM_FU - 1)) ? {FU_W{1'b0}} : winner_s + FU_W'(1);
      res_valid_s         = win_pkt_s.is_branch;
      res_mispredict_s    = win_pkt_s.mispredict;
      res_tag_s           = win_pkt_s.branch_tag;
      cdb_d.valid         = 1'b1;
      cdb_d.rob_idx       = win_pkt_s.rob_idx;
      cdb_d.tag           = win_pkt_s.tag;
      cdb_d.result        = win_pkt_s.result;
      cdb_d.squash_enable = win_pkt_s.is_branch & win_pkt_s.mispredict;
      cdb_d.branch_mask   = win_pkt_s.is_branch ? win_pkt_s.branch_tag : {BMASK_W{1'b0}};
    end else begin
      grant_s = {NUM_FU{1'b0}};
    end
  end

  // Broadcast packet and arbitration pointer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cdb_q    <= {$bits(cdb_packet_t){1'b0}};
      rr_ptr_q <= {FU_W{1'b0}};
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign cdb_valid         = cdb_q.valid;
  assign cdb_rob_idx       = cdb_q.rob_idx;
  assign cdb_tag           = cdb_q.tag;
  assign cdb_result        = cdb_q.result;
  assign cdb_squash_enable = cdb_q.squash_enable;
  assign cdb_branch_mask   = cdb_q.branch_mask;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: hand-derived broadcast order per scenario,
// checked by a negedge monitor plus inline checks in each scenario task.
module tb_cdb_broadcaster;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  fu_valid;
  logic [3:0]  fu_ready;
  logic [19:0] fu_rob_idx;
  logic [23:0] fu_tag;
  logic [127:0] fu_result;
  logic [15:0] fu_branch_mask;
  logic [3:0]  fu_is_branch;
  logic [3:0]  fu_mispredict;
  logic [15:0] fu_branch_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        cdb_squash_enable;
  logic [3:0]  cdb_branch_mask;

  typedef struct packed {
    logic [4:0]  rob;
    logic [5:0]  tag;
    logic [31:0] res;
    logic        sq;
    logic [3:0]  bm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  cdb_broadcaster dut (
    .clock             (clock),
    .reset             (reset),
    .fu_valid          (fu_valid),
    .fu_ready          (fu_ready),
    .fu_rob_idx        (fu_rob_idx),
    .fu_tag            (fu_tag),
    .fu_result         (fu_result),
    .fu_branch_mask    (fu_branch_mask),
    .fu_is_branch      (fu_is_branch),
    .fu_mispredict     (fu_mispredict),
    .fu_branch_tag     (fu_branch_tag),
    .cdb_valid         (cdb_valid),
    .cdb_rob_idx       (cdb_rob_idx),
    .cdb_tag           (cdb_tag),
    .cdb_result        (cdb_result),
    .cdb_squash_enable (cdb_squash_enable),
    .cdb_branch_mask   (cdb_branch_mask)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every broadcast must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (cdb_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bcast: got rob=%0d tag=%0d res=%h, required no broadcast",
                   cdb_rob_idx, cdb_tag, cdb_result);
        end else begin
          mon_e = exp_q.pop_front();
          if ({cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask} !== mon_e) begin
            errors++;
            $display("FAIL bcast_fields: got rob=%0d tag=%0d res=%h sq=%b bm=%b, required rob=%0d tag=%0d res=%h sq=%b bm=%b",
                     cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask,
                     mon_e.rob, mon_e.tag, mon_e.res, mon_e.sq, mon_e.bm);
          end
        end
      end else if ({cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask} !== 48'h0) begin
        errors++;
        $display("FAIL idle_fields: got %h, required 0",
                 {cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_fu(input int i, input logic [4:0] rob, input logic [5:0] tag,
                          input logic [31:0] res, input logic [3:0] bm, input logic br,
                          input logic mp, input logic [3:0] bt);
    fu_valid[i]           = 1'b1;
    fu_rob_idx[i*5 +: 5]  = rob;
    fu_tag[i*6 +: 6]      = tag;
    fu_result[i*32 +: 32] = res;
    fu_branch_mask[i*4 +: 4] = bm;
    fu_is_branch[i]       = br;
    fu_mispredict[i]      = mp;
    fu_branch_tag[i*4 +: 4] = bt;
  endtask

  task automatic idle_fu(input int i);
    drive_fu(i, 5'd0, 6'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    fu_valid[i] = 1'b0;
  endtask

  task automatic expect_bc(input logic [4:0] rob, input logic [5:0] tag, input logic [31:0] res,
                           input logic sq, input logic [3:0] bm);
    exp_t e;
    e.rob = rob; e.tag = tag; e.res = res; e.sq = sq; e.bm = bm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle_fu(i);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", cdb_valid);
    end
    checks++;
    if ({cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask} !== 48'h0) begin
      errors++; $display("FAIL reset_fields: got %h, required 0",
                         {cdb_rob_idx, cdb_tag, cdb_result, cdb_squash_enable, cdb_branch_mask});
    end
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++; $display("FAIL reset_ready: got %b, required 1111", fu_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    drive_fu(0, 5'd3, 6'd12, 32'hDEAD, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd3, 6'd12, 32'hDEAD, 1'b0, 4'b0000);
    tick();
    idle_fu(0);
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got %b, required 0", cdb_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency: got %b, required 1", cdb_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_drop: got %b, required 0", cdb_valid);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int nb = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_fu(i, 5'(i + 1), 6'(10 + i), 32'h1000 + 32'(i), 4'b0000, 1'b0, 1'b0, 4'b0000);
      expect_bc(5'(i + 1), 6'(10 + i), 32'h1000 + 32'(i), 1'b0, 4'b0000);
    end
    tick();
    for (int i = 0; i < 4; i++) idle_fu(i);
    drive_fu(2, 5'd9, 6'd20, 32'h2222, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd9, 6'd20, 32'h2222, 1'b0, 4'b0000);
    tick();
    idle_fu(2);
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      if (cdb_valid === 1'b1) nb++;
      tick();
    end
    checks++;
    if (nb != 5) begin
      errors++; $display("FAIL rr_count: got %0d broadcasts, required 5", nb);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    expect_bc(5'd1, 6'd1, 32'hA000, 1'b0, 4'b0000);
    expect_bc(5'd11, 6'd11, 32'hB000, 1'b0, 4'b0000);
    expect_bc(5'd2, 6'd2, 32'hA001, 1'b0, 4'b0000);
    expect_bc(5'd12, 6'd12, 32'hB001, 1'b0, 4'b0000);
    expect_bc(5'd3, 6'd3, 32'hA002, 1'b0, 4'b0000);
    expect_bc(5'd13, 6'd13, 32'hB002, 1'b0, 4'b0000);
    drive_fu(0, 5'd1, 6'd1, 32'hA000, 4'b0000, 1'b0, 1'b0, 4'b0000);
    drive_fu(1, 5'd11, 6'd11, 32'hB000, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    drive_fu(0, 5'd2, 6'd2, 32'hA001, 4'b0000, 1'b0, 1'b0, 4'b0000);
    drive_fu(1, 5'd12, 6'd12, 32'hB001, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    @(negedge clock);
    checks++;
    if (fu_ready !== 4'b1101) begin
      errors++; $display("FAIL bp_full: got %b, required 1101", fu_ready);
    end
    drive_fu(0, 5'd3, 6'd3, 32'hA002, 4'b0000, 1'b0, 1'b0, 4'b0000);
    drive_fu(1, 5'd13, 6'd13, 32'hB002, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    @(negedge clock);
    checks++;
    if (fu_ready !== 4'b1110) begin
      errors++; $display("FAIL bp_release: got %b, required 1110", fu_ready);
    end
    idle_fu(0);
    tick();
    idle_fu(1);
    repeat (6) tick();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_fu(2, 5'd1, 6'd1, 32'h00D0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd1, 6'd1, 32'h00D0, 1'b0, 4'b0000);
    tick();
    idle_fu(2);
    drive_fu(0, 5'd2, 6'd2, 32'h00A0, 4'b0010, 1'b0, 1'b0, 4'b0000);
    drive_fu(1, 5'd3, 6'd3, 32'h00A1, 4'b0001, 1'b0, 1'b0, 4'b0000);
    drive_fu(3, 5'd4, 6'd4, 32'h00B0, 4'b0000, 1'b1, 1'b1, 4'b0010);
    expect_bc(5'd4, 6'd4, 32'h00B0, 1'b1, 4'b0010);
    expect_bc(5'd3, 6'd3, 32'h00A1, 1'b0, 4'b0000);
    tick();
    idle_fu(0); idle_fu(1); idle_fu(3);
    drive_fu(2, 5'd5, 6'd5, 32'h00A2, 4'b0011, 1'b0, 1'b0, 4'b0000);
    tick();
    idle_fu(2);
    @(negedge clock);
    checks++;
    if ({cdb_valid, cdb_squash_enable, cdb_branch_mask} !== 6'b11_0010) begin
      errors++; $display("FAIL mp_squash: got v/sq/bm=%b, required 110010",
                         {cdb_valid, cdb_squash_enable, cdb_branch_mask});
    end
    repeat (5) tick();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mp_drain: got %0d left, required 0", exp_q.size());
    end
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++; $display("FAIL mp_empty: got %b, required 1111", fu_ready);
    end
  endtask

  task automatic test_correct_predict();
    do_reset();
    drive_fu(2, 5'd6, 6'd6, 32'h00D1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd6, 6'd6, 32'h00D1, 1'b0, 4'b0000);
    tick();
    idle_fu(2);
    drive_fu(3, 5'd7, 6'd7, 32'h00B1, 4'b0000, 1'b1, 1'b0, 4'b0100);
    drive_fu(1, 5'd8, 6'd8, 32'h00E0, 4'b0110, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd7, 6'd7, 32'h00B1, 1'b0, 4'b0100);
    tick();
    idle_fu(3); idle_fu(1);
    drive_fu(0, 5'd9, 6'd9, 32'h00B2, 4'b0000, 1'b1, 1'b1, 4'b0100);
    drive_fu(2, 5'd10, 6'd10, 32'h00F0, 4'b0100, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd9, 6'd9, 32'h00B2, 1'b1, 4'b0100);
    expect_bc(5'd8, 6'd8, 32'h00E0, 1'b0, 4'b0000);
    expect_bc(5'd10, 6'd10, 32'h00F0, 1'b0, 4'b0000);
    tick();
    idle_fu(0); idle_fu(2);
    repeat (6) tick();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cp_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_fu(i, 5'(20 + i), 6'(30 + i), 32'h5000 + 32'(i), 4'b0000, 1'b0, 1'b0, 4'b0000);
    end
    repeat (3) tick();
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: got %b, required 1", cdb_valid);
    end
    for (int i = 0; i < 4; i++) idle_fu(i);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got %b, required 0", cdb_valid);
    end
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++; $display("FAIL rst_mid_ready: got %b, required 1111", fu_ready);
    end
    exp_q.delete();
    mon_en = 1'b1;
    repeat (6) tick();
    drive_fu(1, 5'd11, 6'd11, 32'h6060, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_bc(5'd11, 6'd11, 32'h6060, 1'b0, 4'b0000);
    tick();
    idle_fu(1);
    repeat (4) tick();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset    = 1'b0;
    fu_valid = 4'b0000;
    fu_rob_idx = 20'h0; fu_tag = 24'h0; fu_result = 128'h0;
    fu_branch_mask = 16'h0; fu_is_branch = 4'b0000; fu_mispredict = 4'b0000;
    fu_branch_tag = 16'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mispredict();
    test_correct_predict();
    test_reset_midflight();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
